axi_wr_arbiter_rr: RTL

AXI_WR_ARBITER_RR -- requirements
Module: axi_wr_arbiter_rr

---
 rtl/axi_wr_arbiter_rr_if.sv | 32 +++
 rtl/axi_wr_arbiter_rr.sv | 115 +++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter_rr_if.sv
// Write-path arbitration bundle: per-master AW requests, post-mux slave
// handshakes, and the arbiter's grant/status outputs.
// Ports: m_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready
//        (into the arbiter); grant, grant_idx, busy, beat_cnt (out of it).
interface axi_wr_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int IDXW        = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] m_awvalid;
  logic                   s_awready;
  logic                   s_wvalid;
  logic                   s_wready;
  logic                   s_wlast;
  logic                   s_bvalid;
  logic                   s_bready;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDXW-1:0]        grant_idx;
  logic                   busy;
  logic [8:0]             beat_cnt;

  // Arbiter side.
  modport slave (
    input  m_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    output grant, grant_idx, busy, beat_cnt
  );

  // Environment side (masters plus downstream slave).
  modport master (
    output m_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    input  grant, grant_idx, busy, beat_cnt
  );
endinterface

// File: rtl/axi_wr_arbiter_rr.sv
// Write-channel arbiter: grants one master the AW/W/B path for a whole transaction.
// Latency: grant/busy appear 1 cycle after a request is seen in IDLE; 1 idle cycle between transactions.
// Backpressure: grant held until B handshake; other requests wait, W/B in IDLE ignored.
// Ports: ACLK, ARESETn (async, active-low), bus (axi_wr_arbiter_rr_if.slave).
module axi_wr_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int PRIO_MODE   = 0,   // 0 = round-robin, 1 = fixed priority (lowest index)
  parameter int IDXW        = $clog2(NUM_MASTERS)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_wr_arbiter_rr_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                 state;
  logic [IDXW-1:0]        ptr;
  logic                   wlast_seen;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDXW-1:0]        grant_idx_q;
  logic                   busy_q;
  logic [8:0]             beat_cnt_q;

  logic                   win_vld;
  logic [IDXW-1:0]        win_idx;
  int                     cand;

  logic w_hs;
  logic wlast_hs;
  logic aw_hs;
  logic b_hs;

  assign w_hs     = bus.s_wvalid & bus.s_wready;
  assign wlast_hs = w_hs & bus.s_wlast;
  assign aw_hs    = bus.m_awvalid[grant_idx_q] & bus.s_awready;
  assign b_hs     = bus.s_bvalid & bus.s_bready;

  // Winner search. Round-robin starts at ptr and wraps; fixed priority
  // starts at 0 so the lowest requester always wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (PRIO_MODE == 1) ? i : int'(ptr) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!win_vld && bus.m_awvalid[cand]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(cand);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      ptr         <= '0;
      wlast_seen  <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      // Beats count in ADDR too, since W may run ahead of AW.
      if ((state == ADDR || state == DATA) && w_hs && beat_cnt_q != 9'd511)
        beat_cnt_q <= beat_cnt_q + 9'd1;

      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q     <= NUM_MASTERS'(1) << win_idx;
            grant_idx_q <= win_idx;
            busy_q      <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            // A last beat seen earlier or in this same cycle means the
            // data phase is already complete.
            state <= (wlast_seen || wlast_hs) ? RESP : DATA;
          end else if (wlast_hs) begin
            wlast_seen <= 1'b1;
          end
        end
        DATA: begin
          if (wlast_hs) state <= RESP;
        end
        RESP: begin
          if (b_hs) begin
            state      <= IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
            wlast_seen <= 1'b0;
            ptr        <= (grant_idx_q == IDXW'(NUM_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule
